// File: rtl/xcvr_ref_clk_fwd_gen.sv
// Forwarded reference-clock generator: builds a glitch-free square wave of programmable
// half-period from the fabric clock. It also produces the pad enable, a sync strobe and a period count.
module xcvr_ref_clk_fwd_gen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_half_i,
    output logic             ref_clk_out_o,
    output logic             ref_clk_oe_o,
    output logic             active_o,
    output logic             sync_pulse_o,
    output logic [CNT_W-1:0] period_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StHi,
        StLo,
        StTail
    } state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   period_cnt_q;
    logic               sync_q;
    logic [DIV_W-1:0]   div_sat;

    // A zero divisor would give a zero-length phase, so it is clamped to one.
    assign div_sat = (div_half_i == '0) ? DIV_W'(1) : div_half_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            div_q        <= DIV_W'(1);
            period_cnt_q <= '0;
            sync_q       <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_q      <= StPrep;
                        div_q        <= div_sat;
                        period_cnt_q <= '0;
                    end
                end
                StPrep: begin
                    state_q      <= StHi;
                    cnt_q        <= div_q - 1'b1;
                    period_cnt_q <= period_cnt_q + 1'b1;
                    sync_q       <= 1'b1;
                end
                StHi: begin
                    // EN is deliberately ignored here: a started period always completes.
                    if (cnt_q == '0) begin
                        state_q <= StLo;
                        cnt_q   <= div_q - 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StLo: begin
                    if (cnt_q == '0) begin
                        if (en_i) begin
                            state_q      <= StHi;
                            div_q        <= div_sat;
                            cnt_q        <= div_sat - 1'b1;
                            period_cnt_q <= period_cnt_q + 1'b1;
                            sync_q       <= 1'b1;
                        end else begin
                            state_q <= StTail;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StTail: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Pad enable brackets the waveform by one low cycle on each side.
    assign ref_clk_out_o = (state_q == StHi);
    assign ref_clk_oe_o  = (state_q != StIdle);
    assign active_o      = (state_q == StHi) || (state_q == StLo);
    assign sync_pulse_o  = sync_q;
    assign period_cnt_o  = period_cnt_q;

endmodule

// File: tb/tb_xcvr_ref_clk_fwd_gen.sv
// Randomised bench for xcvr_ref_clk_fwd_gen, checked against a period/phase-position model.
module tb_xcvr_ref_clk_fwd_gen;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div_half;
    logic             ref_clk_out;
    logic             ref_clk_oe;
    logic             active;
    logic             sync_pulse;
    logic [CNT_W-1:0] period_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a run is a prep cycle, whole periods indexed by position 0..2N-1, then a tail cycle.
    bit          m_prep, m_run, m_tail;
    int          m_pos, m_n;
    int unsigned m_pcnt;

    xcvr_ref_clk_fwd_gen #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .div_half_i   (div_half),
        .ref_clk_out_o(ref_clk_out),
        .ref_clk_oe_o (ref_clk_oe),
        .active_o     (active),
        .sync_pulse_o (sync_pulse),
        .period_cnt_o (period_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prep = 0; m_run = 0; m_tail = 0; m_pos = 0; m_n = 1; m_pcnt = 0;
    endtask

    function automatic int n_of(input logic [DIV_W-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_step();
        if (m_prep) begin
            m_prep = 0; m_run = 1; m_pos = 0; m_pcnt = (m_pcnt + 1) % CNT_MOD;
        end else if (m_tail) begin
            m_tail = 0;
        end else if (m_run) begin
            if (m_pos == 2 * m_n - 1) begin
                if (en) begin
                    m_n = n_of(div_half); m_pos = 0; m_pcnt = (m_pcnt + 1) % CNT_MOD;
                end else begin
                    m_run = 0; m_tail = 1;
                end
            end else begin
                m_pos++;
            end
        end else if (en) begin
            m_prep = 1; m_n = n_of(div_half); m_pcnt = 0;
        end
    endtask

    task automatic check_all();
        check("ref_clk_out", 32'(ref_clk_out), 32'(m_run && m_pos < m_n));
        check("ref_clk_oe", 32'(ref_clk_oe), 32'(m_prep || m_run || m_tail));
        check("active", 32'(active), 32'(m_run));
        check("sync_pulse", 32'(sync_pulse), 32'(m_run && m_pos == 0));
        check("period_cnt", 32'(period_cnt), m_pcnt);
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit saw_max, saw_wrap;
        int guard;
        rst_n = 1'b0; en = 1'b0; div_half = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();

        // Steady run with N=3.
        en = 1'b1; div_half = 8'd3;
        repeat (40) cycle();

        // Drop EN on the second HI cycle with N=4.
        div_half = 8'd4;
        guard = 0;
        while (!(m_run && m_pos == 1 && m_n == 4) && guard < 50) begin
            cycle(); guard++;
        end
        check("reach_hi2", 32'(guard < 50), 32'd1);
        en = 1'b0;
        repeat (12) cycle();

        // N=1 via DIV_HALF=0, then change 2 -> 5 mid-HI.
        en = 1'b1; div_half = '0;
        repeat (20) cycle();
        div_half = 8'd2;
        repeat (10) cycle();
        guard = 0;
        while (!(m_run && m_pos == 0 && m_n == 2) && guard < 20) begin
            cycle(); guard++;
        end
        div_half = 8'd5;
        repeat (30) cycle();

        // Asynchronous reset mid-LO with N=3.
        div_half = 8'd3;
        guard = 0;
        while (!(m_run && m_n == 3 && m_pos >= 3) && guard < 50) begin
            cycle(); guard++;
        end
        check("reach_lo", 32'(guard < 50), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cycle();

        // Randomised EN and DIV_HALF.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 14) == 0) div_half = DIV_W'($urandom_range(0, 5));
            cycle();
        end

        // Period counter wrap at N=1.
        en = 1'b0;
        repeat (12) cycle();
        en = 1'b1; div_half = '0;
        saw_max = 0; saw_wrap = 0;
        for (int i = 0; i < 2 * CNT_MOD + 30; i++) begin
            cycle();
            if (period_cnt == CNT_W'(CNT_MOD - 1)) saw_max = 1;
            if (saw_max && period_cnt == '0 && sync_pulse) saw_wrap = 1;
        end
        check("wrap_seen", 32'(saw_max && saw_wrap), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
